// File: rtl/posit_defines.sv
// Shared helpers for the posit decode pipeline: derived field widths and the
// flag bundle that travels with every beat.
package posit_defines;

  // Signed scale width: enough for +/-(NBITS-2)*2^ES plus the exponent.
  function automatic int scale_w(input int nbits, input int es);
    return $clog2(nbits) + es + 1;
  endfunction

  // Fraction bits left after sign, the shortest regime (2 bits) and exponent.
  function automatic int frac_w(input int nbits, input int es);
    return nbits - es - 3;
  endfunction

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
  } flags_t;

endpackage

// File: rtl/posit_regime_count.sv
// Combinational leading-run counter: length of the run of bits equal to the MSB
// and the polarity of that run (1 = run of ones).
module posit_regime_count #(
  parameter int  W   = 31,
  localparam int M_W = $clog2(W + 1)
) (
  input  logic [W-1:0]   i_bits,
  output logic [M_W-1:0] o_run,
  output logic           o_pol
);

  logic w_found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional update, otherwise synthesis infers a latch.
    o_pol   = i_bits[W-1];
    o_run   = M_W'(W);
    w_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!w_found && (i_bits[i] != o_pol)) begin
        o_run   = M_W'(W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_extract_pipe.sv
// 3-stage posit decoder with valid/ready flow control and a pass-through tag.
// Optional zero/NaR output counters are enabled by POSIT_EXTRACT_SPECIAL_CNT_EN.
module posit_extract_pipe
  import posit_defines::*;
#(
  parameter int  NBITS   = 32,
  parameter int  ES      = 2,
  parameter int  TAG_W   = 8,
  localparam int SCALE_W = scale_w(NBITS, ES),
  localparam int FRAC_W  = frac_w(NBITS, ES)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NBITS-1:0]          in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic                      out_zero,
  output logic                      out_inf,
  output logic signed [SCALE_W-1:0] out_scale,
  output logic [FRAC_W-1:0]         out_fraction,
  output logic [NBITS-2:0]          out_abs,
  output logic [TAG_W-1:0]          out_tag
`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
  ,
  input  logic                      cnt_clear,
  output logic [31:0]               zero_cnt,
  output logic [31:0]               inf_cnt
`endif
);

  localparam int M_W = $clog2(NBITS);

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      inf;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         fraction;
  } value_t;

  typedef struct packed {
    flags_t           flags;
    logic [NBITS-2:0] abs;
    logic [TAG_W-1:0] tag;
  } s1_t;

  // sh is the regime width minus 2, so S3 only shifts the bits below the
  // shortest possible regime.
  typedef struct packed {
    flags_t                    flags;
    logic [NBITS-2:0]          abs;
    logic signed [SCALE_W-1:0] k;
    logic [M_W-1:0]            sh;
    logic [TAG_W-1:0]          tag;
  } s2_t;

  typedef struct packed {
    value_t           val;
    logic [NBITS-2:0] abs;
    logic [TAG_W-1:0] tag;
  } s3_t;

  logic r_v1, r_v2, r_v3;
  s1_t  r_s1, w_s1;
  s2_t  r_s2, w_s2;
  s3_t  r_s3, w_s3;
  logic w_ld1, w_ld2, w_ld3;

  assign w_ld3    = ~r_v3 | out_ready;
  assign w_ld2    = ~r_v2 | w_ld3;
  assign w_ld1    = ~r_v1 | w_ld2;
  assign in_ready = w_ld1;

  always_comb begin
    w_s1            = '0;
    w_s1.flags.sign = in_data[NBITS-1];
    w_s1.flags.zero = (in_data == '0);
    w_s1.flags.inf  = in_data[NBITS-1] & (in_data[NBITS-2:0] == '0);
    w_s1.abs        = in_data[NBITS-1] ? (~in_data[NBITS-2:0] + {{(NBITS-2){1'b0}}, 1'b1})
                                       : in_data[NBITS-2:0];
    w_s1.tag        = in_tag;
  end

  logic [M_W-1:0]            w_run;
  logic                      w_pol;
  logic signed [SCALE_W-1:0] w_m;

  posit_regime_count #(.W(NBITS - 1)) u_regime (
    .i_bits (r_s1.abs),
    .o_run  (w_run),
    .o_pol  (w_pol)
  );

  always_comb begin
    w_m        = signed'(SCALE_W'(w_run));
    w_s2       = '0;
    w_s2.flags = r_s1.flags;
    w_s2.abs   = r_s1.abs;
    w_s2.tag   = r_s1.tag;
    w_s2.k     = w_pol ? (w_m - SCALE_W'(1)) : -w_m;
    w_s2.sh    = (w_run == M_W'(NBITS - 1)) ? (w_run - M_W'(2)) : (w_run - M_W'(1));
  end

  logic [NBITS-4:0]          w_body;
  logic signed [SCALE_W-1:0] w_exp;

  assign w_body = r_s2.abs[NBITS-4:0] << r_s2.sh;

  generate
    if (ES > 0) begin : g_exp
      assign w_exp = SCALE_W'(w_body[NBITS-4 -: ES]);
    end else begin : g_no_exp
      assign w_exp = '0;
    end
  endgenerate

  always_comb begin
    w_s3          = '0;
    w_s3.val.sign = r_s2.flags.sign;
    w_s3.val.zero = r_s2.flags.zero;
    w_s3.val.inf  = r_s2.flags.inf;
    w_s3.abs      = r_s2.abs;
    w_s3.tag      = r_s2.tag;
    if (!r_s2.flags.zero && !r_s2.flags.inf) begin
      w_s3.val.scale    = (r_s2.k <<< ES) + w_exp;
      w_s3.val.fraction = w_body[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every stage samples
    // the pre-edge value of the stage in front of it.
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      if (w_ld1) begin
        r_v1 <= in_valid;
        if (in_valid) r_s1 <= w_s1;
      end
      if (w_ld2) begin
        r_v2 <= r_v1;
        if (r_v1) r_s2 <= w_s2;
      end
      if (w_ld3) begin
        r_v3 <= r_v2;
        if (r_v2) r_s3 <= w_s3;
      end
    end
  end

  assign out_valid    = r_v3;
  assign out_sign     = r_s3.val.sign;
  assign out_zero     = r_s3.val.zero;
  assign out_inf      = r_s3.val.inf;
  assign out_scale    = r_s3.val.scale;
  assign out_fraction = r_s3.val.fraction;
  assign out_abs      = r_s3.abs;
  assign out_tag      = r_s3.tag;

`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
  logic        w_out_hs;
  logic [31:0] r_zero_cnt, r_inf_cnt;

  assign w_out_hs = r_v3 & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_cnt <= '0;
      r_inf_cnt  <= '0;
    end else if (cnt_clear) begin
      r_zero_cnt <= '0;
      r_inf_cnt  <= '0;
    end else begin
      if (w_out_hs && r_s3.val.zero && (r_zero_cnt != '1)) r_zero_cnt <= r_zero_cnt + 32'd1;
      if (w_out_hs && r_s3.val.inf  && (r_inf_cnt  != '1)) r_inf_cnt  <= r_inf_cnt  + 32'd1;
    end
  end

  assign zero_cnt = r_zero_cnt;
  assign inf_cnt  = r_inf_cnt;
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Scoreboard bench for posit_extract_pipe (NBITS=32, ES=2): directed posit
// vectors, latency/throughput, random back-pressure and mid-flight reset.
module tb_posit_extract_pipe;

  localparam int NBITS   = 32;
  localparam int ES      = 2;
  localparam int TAG_W   = 8;
  localparam int SCALE_W = 8;
  localparam int FRAC_W  = 27;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               inf;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]  fraction;
    logic [NBITS-2:0]   abs;
    logic [TAG_W-1:0]   tag;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [NBITS-1:0]          in_data;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sign;
  logic                      out_zero;
  logic                      out_inf;
  logic signed [SCALE_W-1:0] out_scale;
  logic [FRAC_W-1:0]         out_fraction;
  logic [NBITS-2:0]          out_abs;
  logic [TAG_W-1:0]          out_tag;
`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
  logic                      cnt_clear;
  logic [31:0]               zero_cnt;
  logic [31:0]               inf_cnt;
`endif

  posit_extract_pipe #(.NBITS(NBITS), .ES(ES), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_zero     (out_zero),
    .out_inf      (out_inf),
    .out_scale    (out_scale),
    .out_fraction (out_fraction),
    .out_abs      (out_abs),
    .out_tag      (out_tag)
`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
    ,
    .cnt_clear    (cnt_clear),
    .zero_cnt     (zero_cnt),
    .inf_cnt      (inf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hand-decoded vectors (tag field filled in at issue time).
  logic [31:0] vec_data [10] = '{
    32'h40000000, 32'h48000000, 32'h44000000, 32'h38000000, 32'hC0000000,
    32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000001, 32'hBC000000
  };
  beat_t vec_exp [10] = '{
    '{1'b0, 1'b0, 1'b0, 8'h00, 27'h0000000, 31'h40000000, 8'h00},  // 1.0
    '{1'b0, 1'b0, 1'b0, 8'h01, 27'h0000000, 31'h48000000, 8'h00},  // 2.0
    '{1'b0, 1'b0, 1'b0, 8'h00, 27'h4000000, 31'h44000000, 8'h00},  // 1.5
    '{1'b0, 1'b0, 1'b0, 8'hFF, 27'h0000000, 31'h38000000, 8'h00},  // 0.5
    '{1'b1, 1'b0, 1'b0, 8'h00, 27'h0000000, 31'h40000000, 8'h00},  // -1.0
    '{1'b1, 1'b0, 1'b1, 8'h00, 27'h0000000, 31'h00000000, 8'h00},  // NaR
    '{1'b0, 1'b1, 1'b0, 8'h00, 27'h0000000, 31'h00000000, 8'h00},  // zero
    '{1'b0, 1'b0, 1'b0, 8'h78, 27'h0000000, 31'h7FFFFFFF, 8'h00},  // maxpos
    '{1'b0, 1'b0, 1'b0, 8'h88, 27'h0000000, 31'h00000001, 8'h00},  // minpos
    '{1'b1, 1'b0, 1'b0, 8'h00, 27'h4000000, 31'h44000000, 8'h00}   // -1.5
  };

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_out    = 0;
  int    occ      = 0;
  int    cyc      = 0;
  logic  stall    = 1'b0;
  logic  bp       = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = stall ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: scoreboard pop on each output handshake, hold-while-stalled and
  // ready checks against an occupancy model of accepted-but-undelivered beats.
  initial begin : monitor
    beat_t act;
    beat_t held_val;
    beat_t e;
    logic  held;
    held     = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      act = {out_sign, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag};
      if (!reset_n) begin
        occ  = 0;
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_hold", act, held_val);
        end
        check("in_ready", in_ready, !((occ == 3) && !out_ready));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got tag %0h, expected no output (t=%0t)", out_tag, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", act, e);
            n_out++;
          end
        end
        held     = out_valid && !out_ready;
        held_val = act;
        occ      = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  // Issue one beat; returns #1 after the accepting edge.
  task automatic send(input int idx, input logic [TAG_W-1:0] tag);
    beat_t e;
    logic  hs;
    int    n;
    e     = vec_exp[idx];
    e.tag = tag;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = vec_data[idx];
    in_tag   = tag;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      n++;
    end
    check("send_accept", hs, 1'b1);
    if (!hs) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int start;
    int n;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_tag   = '0;
`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
    cnt_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {out_sign, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Latency: out_valid in the third cycle after the accepting edge's cycle.
    send(0, 8'h01);
    check("lat_c1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_c2", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_c3", out_valid, 1'b1);
    drain(20);

    // Full-rate stream of all vectors.
    start = cyc;
    for (int i = 0; i < 10; i++) send(i, TAG_W'(8'h10 + i));
    check("throughput_cycles", cyc - start, 10);
    drain(20);

    // Random back-pressure, tags 0..9.
    base = n_out;
    bp   = 1'b1;
    for (int i = 0; i < 10; i++) send(i, TAG_W'(i));
    drain(400);
    bp = 1'b0;
    check("bp_count", n_out - base, 10);

    // Reset with three beats in flight.
    stall = 1'b1;
    @(posedge clk);
    #1;
    send(6, 8'hE0);
    send(5, 8'hE1);
    send(7, 8'hE2);
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_in_ready", in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_outputs", {out_sign, out_zero, out_inf, out_scale, out_fraction, out_abs, out_tag}, '0);
    stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_beat", n_out - base, 0);
    check("post_rst_valid", out_valid, 1'b0);
    send(3, 8'h5A);
    drain(20);

`ifdef POSIT_EXTRACT_SPECIAL_CNT_EN
    check("cnt_rst_zero", zero_cnt, 32'd0);
    check("cnt_rst_inf", inf_cnt, 32'd0);
    for (int i = 0; i < 4; i++) send(6, TAG_W'(8'h30 + i));
    send(5, 8'h40);
    send(5, 8'h41);
    drain(20);
    check("zero_cnt", zero_cnt, 32'd4);
    check("inf_cnt", inf_cnt, 32'd2);
    send(6, 8'h50);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_wait", out_valid, 1'b1);
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    check("zero_cnt_clear", zero_cnt, 32'd0);
    drain(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/posit_extract_pipe.md
Name: posit_extract_pipe

Overview:
- Pipelined, parametrised posit decoder with valid/ready streaming. Splits an NBITS/ES posit into sign, zero/inf flags, signed scale (k*2^ES + e), fraction and absolute value.
- Sits in front of the posit add/mul datapaths in the PairHMM AFU stream.
- Adds back-pressure, a sideband tag and any NBITS/ES combination.

Parameters:
- NBITS, 32, posit width (8..64).
- ES, 2, exponent field width (0..4).
- TAG_W, 8, sideband tag width carried alongside the data.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input
- in_data  in  NBITS  posit word
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sign  out  1  posit sign bit
- out_zero  out  1  input was 0
- out_inf  out  1  input was NaR (1 followed by all zeros)
- out_scale  out  SCALE_W  signed scale
- out_fraction  out  FRAC_W  fraction bits after the hidden 1, MSB-aligned
- out_abs  out  NBITS-1  two's-complement magnitude without sign
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valids 0, all data registers 0, so every output reads 0. in_ready is 1 after reset.
- Reset mid-operation: all in-flight beats are dropped and no output handshake occurs.
- Pipeline, 3 register stages:
  - S1: sign, zero/inf detect, conditional two's-complement negate.
  - S2: leading-run count on bits [NBITS-2:0]. A run of m ones gives k = m-1; a run of m zeros gives k = -m. Regime width = min(m+1, NBITS-1).
  - S3: left shift past the regime; take ES exponent bits (zero-filled when truncated) and FRAC_W fraction bits (zero-filled). Scale = k*2^ES + e.
- Arithmetic: scale is computed in SCALE_W signed, with no overflow possible.
- Latency: 3 cycles from the input handshake to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Handshake:
  - Transfer occurs when valid & ready.
  - Each stage loads when its valid is 0 or the downstream stage accepts.
  - in_ready = ~v1 | (stage-1 advance); this is a combinational ready chain, with no bubbles under continuous flow.
  - out_valid and all output data are held stable while out_ready = 0.
  - Upstream must not alter in_data or in_tag while in_valid=1 and in_ready=0.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle.
- Special inputs:
  - zero or inf: scale=0, fraction=0, abs=0.
  - maxpos: k=NBITS-2.
  - minpos: k=-(NBITS-2).

Optional Feature:
- Macro: POSIT_EXTRACT_SPECIAL_CNT_EN.
- When defined:
  - Adds ports cnt_clear (in, 1), zero_cnt (out, 32) and inf_cnt (out, 32).
  - Counters increment on each output handshake whose out_zero or out_inf is set, and saturate at 0xFFFFFFFF.
  - A synchronous cnt_clear has priority over an increment.
  - Counters reset to 0.
- When undefined: the ports and logic are absent, and the block is otherwise identical.

Decomposition:
- Package posit_defines gains:
  - SCALE_W = $clog2(NBITS)+ES+1
  - FRAC_W = NBITS-ES-3
  - a parametrised struct value_t {sign, zero, inf, scale, fraction}
  - a stage payload struct holding the tag.
- One sub-module: posit_regime_count (combinational leading-run counter returning m and run polarity), instantiated in S2.

Test Plan:
- 1.0 and 2.0, NBITS=32 ES=2, out_ready=1:
  - 0x40000000 -> sign0 scale 0 fraction 0, out_valid exactly 3 cycles later.
  - 0x48000000 -> scale 1.
- 0x44000000 -> scale 0, fraction 0x4000000 (1.5). 0x38000000 -> scale -1, fraction 0.
- Signed and special inputs:
  - 0xC0000000 -> sign1 scale 0 abs 0x40000000.
  - 0x80000000 -> inf=1.
  - 0x00000000 -> zero=1.
  - 0x7FFFFFFF -> scale 120.
  - 0x00000001 -> scale -120.
- Back-pressure:
  - Stream 10 beats with tags 0..9; out_ready toggles randomly.
  - Outputs appear in order with no loss or duplicates; fields stay stable while stalled; in_ready=0 only when all 3 stages are full and out_ready=0.
- reset_n asserted with 3 beats in flight -> out_valid=0 immediately, all outputs 0, no stale beat after release.
- With POSIT_EXTRACT_SPECIAL_CNT_EN:
  - 4 zeros + 2 NaR -> zero_cnt=4, inf_cnt=2.
  - cnt_clear pulsed on a zero handshake -> zero_cnt=0.
